// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: DIGITS-decade BCD up/down counter with load, cascade carry, zero and sticky error flags.
// Optional saturation at the terminal count is enabled by defining BCD_CNT_SATURATE_EN.
module bcd_updown_counter_n #(
  parameter int DIGITS = 2,
  parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
  input  logic                clk_i,
  input  logic                clr_n_i,
  input  logic [4*DIGITS-1:0] d_i,
  input  logic                enable_i,
  input  logic                load_i,
  input  logic                up_i,
  output logic [4*DIGITS-1:0] q_o,
  output logic                co_o,
  output logic                zero_o,
  output logic                err_o
);
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};
  logic [4*DIGITS-1:0] q_q, q_d, cnt, ld;
  logic                err_q, err_d, bad, chain, term;
  logic [3:0]          dig;
  assign term   = up_i ? (q_q == NINES) : (q_q == '0);
  assign co_o   = enable_i & ~load_i & term;
  assign zero_o = (q_q == '0);
  assign q_o    = q_q;
  assign err_o  = err_q;
  // Ripple the carry/borrow through the decades and sanitise each load digit.
  always_comb begin
    cnt   = q_q;
    ld    = '0;
    bad   = 1'b0;
    chain = 1'b1;
    dig   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_q[4*i+:4];
      if (chain) cnt[4*i+:4] = up_i ? (dig == 4'd9 ? 4'd0 : dig + 4'd1) : (dig == 4'd0 ? 4'd9 : dig - 4'd1);
      chain = chain & (up_i ? dig == 4'd9 : dig == 4'd0);
      ld[4*i+:4] = d_i[4*i+:4] > 4'd9 ? 4'd0 : d_i[4*i+:4];
      bad = bad | (d_i[4*i+:4] > 4'd9);
    end
  end
  // Select hold, load or count; ERR only moves on a load.
  always_comb begin
`ifdef BCD_CNT_SATURATE_EN
    q_d = !enable_i ? q_q : load_i ? ld : term ? q_q : cnt;
`else
    q_d = !enable_i ? q_q : load_i ? ld : cnt;
`endif
    err_d = (enable_i & load_i) ? bad : err_q;
  end
  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      q_q   <= RST_VAL;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n: directed self-checking bench for the two-digit BCD counter and a cascaded pair.
module tb_bcd_updown_counter_n;
  logic       clk = 1'b0, clr_n = 1'b0, enable = 1'b0, load = 1'b0, up = 1'b1;
  logic [7:0] d = 8'h00, q;
  logic       co, zero, err;
  logic       c_en = 1'b0, c_up = 1'b1;
  logic [7:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_zero, hi_zero, lo_err, hi_err;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(2), .RST_VAL(8'h00)) dut (
    .clk_i(clk), .clr_n_i(clr_n), .d_i(d), .enable_i(enable), .load_i(load), .up_i(up),
    .q_o(q), .co_o(co), .zero_o(zero), .err_o(err));

  bcd_updown_counter_n #(.DIGITS(2), .RST_VAL(8'h99)) u_lo (
    .clk_i(clk), .clr_n_i(clr_n), .d_i(8'h00), .enable_i(c_en), .load_i(1'b0), .up_i(c_up),
    .q_o(lo_q), .co_o(lo_co), .zero_o(lo_zero), .err_o(lo_err));

  bcd_updown_counter_n #(.DIGITS(2), .RST_VAL(8'h99)) u_hi (
    .clk_i(clk), .clr_n_i(clr_n), .d_i(8'h00), .enable_i(lo_co), .load_i(1'b0), .up_i(c_up),
    .q_o(hi_q), .co_o(hi_co), .zero_o(hi_zero), .err_o(hi_err));

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    #2;
    total++; if (q !== 8'h00 || err !== 1'b0 || zero !== 1'b1) begin bad++; $display("FAIL reset_init q=%h err=%b zero=%b want q=00 err=0 zero=1", q, err, zero); end
    clr_n = 1'b1; enable = 1'b1; load = 1'b1; d = 8'h37;
    step(1);
    total++; if (q !== 8'h37) begin bad++; $display("FAIL reset_preload q=%h want 37", q); end
    load = 1'b0; enable = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    total++; if (q !== 8'h00 || err !== 1'b0) begin bad++; $display("FAIL reset_async q=%h err=%b want q=00 err=0", q, err); end
    clr_n = 1'b1;
    step(3);
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_hold q=%h want 00", q); end
  endtask

  task automatic test_count;
    enable = 1'b1; load = 1'b1; d = 8'h04;
    step(1);
    total++; if (q !== 8'h04) begin bad++; $display("FAIL load04 q=%h want 04", q); end
    load = 1'b0; up = 1'b1;
    step(4);
    total++; if (q !== 8'h08) begin bad++; $display("FAIL up4 q=%h want 08", q); end
    up = 1'b0;
    step(1);
    total++; if (q !== 8'h07) begin bad++; $display("FAIL down1 q=%h want 07", q); end
    up = 1'b1;
    step(2);
    total++; if (q !== 8'h09) begin bad++; $display("FAIL up_to09 q=%h want 09", q); end
    step(1);
    total++; if (q !== 8'h10) begin bad++; $display("FAIL carry10 q=%h want 10", q); end
  endtask

  task automatic test_wrap_up;
    load = 1'b1; d = 8'h98; up = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    total++; if (q !== 8'h99 || co !== 1'b1) begin bad++; $display("FAIL up_tc q=%h co=%b want q=99 co=1", q, co); end
    load = 1'b1; d = 8'h99;
    #1;
    total++; if (co !== 1'b0) begin bad++; $display("FAIL load_wins_co co=%b want 0", co); end
    load = 1'b0;
    #1;
    step(1);
`ifdef BCD_CNT_SATURATE_EN
    total++; if (q !== 8'h99 || co !== 1'b1 || zero !== 1'b0) begin bad++; $display("FAIL up_sat q=%h co=%b zero=%b want q=99 co=1 zero=0", q, co, zero); end
`else
    total++; if (q !== 8'h00 || co !== 1'b0 || zero !== 1'b1) begin bad++; $display("FAIL up_wrap q=%h co=%b zero=%b want q=00 co=0 zero=1", q, co, zero); end
`endif
    load = 1'b1; d = 8'h00;
    step(1);
    load = 1'b0; enable = 1'b0;
    #1;
    total++; if (zero !== 1'b1 || co !== 1'b0) begin bad++; $display("FAIL zero_noen zero=%b co=%b want zero=1 co=0", zero, co); end
    enable = 1'b1;
  endtask

  task automatic test_wrap_down;
    load = 1'b1; d = 8'h10;
    step(1);
    load = 1'b0; up = 1'b0;
    step(1);
    total++; if (q !== 8'h09) begin bad++; $display("FAIL borrow q=%h want 09", q); end
    load = 1'b1; d = 8'h00;
    step(1);
    load = 1'b0;
    #1;
    total++; if (co !== 1'b1) begin bad++; $display("FAIL down_tc co=%b want 1", co); end
    step(1);
`ifdef BCD_CNT_SATURATE_EN
    total++; if (q !== 8'h00) begin bad++; $display("FAIL down_sat q=%h want 00", q); end
`else
    total++; if (q !== 8'h99) begin bad++; $display("FAIL down_wrap q=%h want 99", q); end
`endif
    up = 1'b1;
  endtask

  task automatic test_err;
    load = 1'b1; d = 8'h3C;
    step(1);
    total++; if (q !== 8'h30 || err !== 1'b1) begin bad++; $display("FAIL bad_load q=%h err=%b want q=30 err=1", q, err); end
    load = 1'b0;
    step(2);
    total++; if (q !== 8'h32 || err !== 1'b1) begin bad++; $display("FAIL err_sticky q=%h err=%b want q=32 err=1", q, err); end
    enable = 1'b0; load = 1'b1; d = 8'h25;
    step(1);
    total++; if (q !== 8'h32 || err !== 1'b1) begin bad++; $display("FAIL load_noen q=%h err=%b want q=32 err=1", q, err); end
    enable = 1'b1;
    step(1);
    total++; if (q !== 8'h25 || err !== 1'b0) begin bad++; $display("FAIL good_load q=%h err=%b want q=25 err=0", q, err); end
    d = 8'hCA;
    step(1);
    total++; if (q !== 8'h00 || err !== 1'b1) begin bad++; $display("FAIL both_bad q=%h err=%b want q=00 err=1", q, err); end
    load = 1'b0; enable = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clr err=%b want 0", err); end
    clr_n = 1'b1;
  endtask

  task automatic test_cascade;
    c_en = 1'b0; c_up = 1'b1;
    clr_n = 1'b0;
    #1;
    total++; if (lo_q !== 8'h99 || hi_q !== 8'h99 || lo_co !== 1'b0) begin bad++; $display("FAIL casc_rst lo=%h hi=%h lo_co=%b want 99 99 0", lo_q, hi_q, lo_co); end
    clr_n = 1'b1; c_en = 1'b1;
    #1;
    total++; if (lo_co !== 1'b1 || hi_co !== 1'b1) begin bad++; $display("FAIL casc_co lo_co=%b hi_co=%b want 1 1", lo_co, hi_co); end
    step(1);
`ifdef BCD_CNT_SATURATE_EN
    total++; if (lo_q !== 8'h99 || hi_q !== 8'h99) begin bad++; $display("FAIL casc_sat lo=%h hi=%h want 99 99", lo_q, hi_q); end
`else
    total++; if (lo_q !== 8'h00 || hi_q !== 8'h00) begin bad++; $display("FAIL casc_wrap lo=%h hi=%h want 00 00", lo_q, hi_q); end
    step(5);
    total++; if (lo_q !== 8'h05 || hi_q !== 8'h00) begin bad++; $display("FAIL casc_hold lo=%h hi=%h want 05 00", lo_q, hi_q); end
`endif
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap_up();
    test_wrap_down();
    test_err();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
